// File: rtl/crp16_alu_wb_stage_pkg.sv
// rtl/crp16_alu_wb_stage_pkg.sv - shared state, flag and condition-code definitions
package crp16_alu_wb_stage_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  localparam logic [2:0] COND_AL = 3'b000;
  localparam logic [2:0] COND_EQ = 3'b001;
  localparam logic [2:0] COND_NE = 3'b010;
  localparam logic [2:0] COND_LT = 3'b011;
  localparam logic [2:0] COND_GE = 3'b100;
  localparam logic [2:0] COND_CS = 3'b101;
  localparam logic [2:0] COND_CC = 3'b110;
  localparam logic [2:0] COND_NV = 3'b111;

endpackage

// File: rtl/crp16_alu_wb_stage_cond_eval.sv
// rtl/crp16_alu_wb_stage_cond_eval.sv - branch condition evaluation against NZCV
// Purely combinational so the branch unit can reuse it directly.
module crp16_cond_eval
  import crp16_alu_wb_stage_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [2:0] cond,
  output logic       cond_true
);

  logic n, z, c, v;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign v = flags[FLAG_V];

  always_comb begin
    cond_true = 1'b0;
    case (cond)
      COND_AL: cond_true = 1'b1;
      COND_EQ: cond_true = z;
      COND_NE: cond_true = ~z;
      COND_LT: cond_true = n ^ v;
      COND_GE: cond_true = ~(n ^ v);
      COND_CS: cond_true = c;
      COND_CC: cond_true = ~c;
      default: cond_true = 1'b0;
    endcase
  end

endmodule

// File: rtl/crp16_alu_wb_stage.sv
// rtl/crp16_alu_wb_stage.sv - ALU result skid buffer, NZCV flag register and cond eval
// Head entry drives out_*; the skid entry absorbs one result while the register file stalls.
module crp16_alu_wb_stage
  import crp16_alu_wb_stage_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int REG_AW = 3
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_v,
  input  logic              in_c,
  input  logic              in_n,
  input  logic              in_z,
  input  logic [REG_AW-1:0] in_dest,
  input  logic              in_we,
  input  logic              in_setf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [REG_AW-1:0] out_dest,
  output logic              out_we,
  output logic [3:0]        flags,
  input  logic [2:0]        cond,
  output logic              cond_true
);

  state_t state, state_nxt;

  logic              accept, pop;
  logic              load_head_in, load_head_skid, load_skid, flag_upd;
  logic [DATA_W-1:0] skid_data;
  logic [REG_AW-1:0] skid_dest;
  logic              skid_we;

  assign in_ready  = (state != ST_FULL);
  assign out_valid = (state != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= ST_EMPTY;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    flag_upd       = 1'b0;
    if (flush) begin
      // Flush discards everything, including a same-cycle accept and its flags.
      state_nxt = ST_EMPTY;
    end else begin
      flag_upd = accept & in_setf;
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_nxt    = ST_ONE;
            load_head_in = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !pop) begin
            state_nxt = ST_FULL;
            load_skid = 1'b1;
          end else if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (pop) begin
            state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_nxt      = ST_ONE;
            load_head_skid = 1'b1;
          end
        end
        default: state_nxt = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_data  <= '0;
      out_dest  <= '0;
      out_we    <= 1'b0;
      skid_data <= '0;
      skid_dest <= '0;
      skid_we   <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      if (load_head_in) begin
        out_data <= in_data;
        out_dest <= in_dest;
        out_we   <= in_we;
      end else if (load_head_skid) begin
        out_data <= skid_data;
        out_dest <= skid_dest;
        out_we   <= skid_we;
      end
      if (load_skid) begin
        skid_data <= in_data;
        skid_dest <= in_dest;
        skid_we   <= in_we;
      end
      if (flag_upd) flags <= {in_n, in_z, in_c, in_v};
    end
  end

  crp16_cond_eval u_cond_eval (
    .flags     (flags),
    .cond      (cond),
    .cond_true (cond_true)
  );

endmodule
